// File: rtl/id_stage_hazard.sv
// Decode stage: field split, bypassed register file, immediate extension, control decode,
// load-use hazard detection and registered ID/EX boundary. Optional debug port: ID_DEBUG_PORT_EN.
module id_stage_hazard #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 32,
  parameter int unsigned NB_INST = 32,
  parameter int unsigned NB_REG  = 5,
  parameter int unsigned NB_IMM  = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_ADDR-1:0] i_pc,
  input  logic [NB_INST-1:0] i_instruction,
  input  logic               i_flush,
  input  logic               i_wb_write,
  input  logic [NB_REG-1:0]  i_wb_addr,
  input  logic [NB_DATA-1:0] i_wb_data,
`ifdef ID_DEBUG_PORT_EN
  input  logic               i_dbg_we,
  input  logic [NB_REG-1:0]  i_dbg_addr,
  input  logic [NB_DATA-1:0] i_dbg_wdata,
  output logic [NB_DATA-1:0] o_dbg_rdata,
`endif
  output logic               o_stall,
  output logic               o_valid,
  output logic [NB_ADDR-1:0] o_pc,
  output logic [NB_DATA-1:0] o_data_1,
  output logic [NB_DATA-1:0] o_data_2,
  output logic [NB_DATA-1:0] o_imm,
  output logic [NB_REG-1:0]  o_rs,
  output logic [NB_REG-1:0]  o_rt,
  output logic [NB_REG-1:0]  o_dest,
  output logic [5:0]         o_funct,
  output logic [5:0]         o_opcode,
  output logic               o_reg_write,
  output logic               o_mem_read,
  output logic               o_mem_write
);

  localparam int unsigned DEPTH  = 1 << NB_REG;
  localparam int unsigned NB_OP  = 6;
  localparam int unsigned RS_LSB = NB_INST - NB_OP - NB_REG;
  localparam int unsigned RT_LSB = RS_LSB - NB_REG;
  localparam int unsigned RD_LSB = RT_LSB - NB_REG;

  logic [NB_DATA-1:0] regs [DEPTH];

  logic [NB_OP-1:0]   opcode_c;
  logic [5:0]         funct_c;
  logic [NB_REG-1:0]  rs_c, rt_c, rd_c, dest_c;
  logic [NB_IMM-1:0]  imm_raw_c;
  logic [NB_DATA-1:0] imm_c, data_1_c, data_2_c;
  logic               reg_write_c, mem_read_c, mem_write_c;
  logic               hz_c, bubble_c;

  assign opcode_c  = i_instruction[NB_INST-1 -: NB_OP];
  assign rs_c      = i_instruction[RS_LSB +: NB_REG];
  assign rt_c      = i_instruction[RT_LSB +: NB_REG];
  assign rd_c      = i_instruction[RD_LSB +: NB_REG];
  assign funct_c   = i_instruction[5:0];
  assign imm_raw_c = i_instruction[NB_IMM-1:0];

  // Register file; WB is applied after debug so it wins on a same-index collision
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) regs[NB_REG'(i)] <= '0;
    end else begin
`ifdef ID_DEBUG_PORT_EN
      if (i_dbg_we && (i_dbg_addr != '0)) regs[i_dbg_addr] <= i_dbg_wdata;
`endif
      if (i_wb_write && (i_wb_addr != '0)) regs[i_wb_addr] <= i_wb_data;
    end
  end

  // Reads with write-through bypass of the writeback port
  always_comb begin
    data_1_c = regs[rs_c];
    data_2_c = regs[rt_c];
    if (i_wb_write && (i_wb_addr == rs_c)) data_1_c = i_wb_data;
    if (i_wb_write && (i_wb_addr == rt_c)) data_2_c = i_wb_data;
    if (rs_c == '0) data_1_c = '0;
    if (rt_c == '0) data_2_c = '0;
  end

`ifdef ID_DEBUG_PORT_EN
  assign o_dbg_rdata = (i_dbg_addr == '0) ? '0 : regs[i_dbg_addr];
`endif

  always_comb begin
    imm_c = NB_DATA'(signed'(imm_raw_c));
    case (opcode_c)
      6'h0C, 6'h0D, 6'h0E: imm_c = NB_DATA'(imm_raw_c);
      6'h0F:               imm_c = NB_DATA'(imm_raw_c) << 16;
      default:             ;
    endcase
  end

  always_comb begin
    dest_c      = (opcode_c == '0) ? rd_c : rt_c;
    mem_read_c  = (opcode_c[5:3] == 3'b100);
    mem_write_c = (opcode_c[5:3] == 3'b101);
    reg_write_c = (opcode_c == '0) || (opcode_c[5:3] == 3'b001) || mem_read_c;
  end

  // Load in EX whose destination feeds the instruction now in ID
  assign hz_c = o_valid & o_mem_read & (o_dest != '0) & i_valid &
                ((o_dest == rs_c) | (o_dest == rt_c));
  assign o_stall  = hz_c & ~i_flush & ~i_reset;
  assign bubble_c = i_flush | hz_c | ~i_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid     <= 1'b0;
      o_pc        <= '0;
      o_data_1    <= '0;
      o_data_2    <= '0;
      o_imm       <= '0;
      o_rs        <= '0;
      o_rt        <= '0;
      o_dest      <= '0;
      o_funct     <= '0;
      o_opcode    <= '0;
      o_reg_write <= 1'b0;
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;
    end else if (bubble_c) begin
      o_valid     <= 1'b0;
      o_reg_write <= 1'b0;
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;
    end else begin
      o_valid     <= 1'b1;
      o_pc        <= i_pc;
      o_data_1    <= data_1_c;
      o_data_2    <= data_2_c;
      o_imm       <= imm_c;
      o_rs        <= rs_c;
      o_rt        <= rt_c;
      o_dest      <= dest_c;
      o_funct     <= funct_c;
      o_opcode    <= opcode_c;
      o_reg_write <= reg_write_c;
      o_mem_read  <= mem_read_c;
      o_mem_write <= mem_write_c;
    end
  end

endmodule
